// File: rtl/rv32i_pkg.sv
// RV32I instruction-type codes and base opcodes shared by the encoder,
// the decoder and the control logic.
package rv32i_pkg;

    typedef enum logic [3:0] {
        IT_LOAD   = 4'b0001,
        IT_STORE  = 4'b0010,
        IT_R      = 4'b0011,
        IT_IALU   = 4'b0100,
        IT_BRANCH = 4'b0101,
        IT_JAL    = 4'b0110
    } inst_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int INST_W = 32;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is read straight from
// the storage flops, so the output is registered data with no bypass.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I field bundles into 32-bit instruction words and queues them
// with their byte addresses; unknown types are dropped and counted.
module inst_encoder
    import rv32i_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    inst_type,
    input  logic [4:0]                    rd,
    input  logic [4:0]                    rs1,
    input  logic [4:0]                    rs2,
    input  logic [2:0]                    func3,
    input  logic [6:0]                    func7,
    input  logic [19:0]                   immediate,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic [31:0]                   out_addr,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          illegal,
    output logic [7:0]                    illegal_cnt
);
    logic [INST_W-1:0] word;
    logic              legal;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;

    // Branch/JAL immediates arrive as offset bits with bit 0 already dropped.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (inst_type)
            IT_R:      word = {func7, rs2, rs1, func3, rd, OP_R};
            IT_IALU:   word = {immediate[11:0], rs1, func3, rd, OP_IALU};
            IT_LOAD:   word = {immediate[11:0], rs1, func3, rd, OP_LOAD};
            IT_STORE:  word = {immediate[11:5], rs2, rs1, func3, immediate[4:0], OP_STORE};
            IT_BRANCH: word = {immediate[11], immediate[9:4], rs2, rs1, func3,
                               immediate[3:0], immediate[10], OP_BRANCH};
            IT_JAL:    word = {immediate[19], immediate[9:0], immediate[10],
                               immediate[18:11], rd, OP_JAL};
            default:   legal = 1'b0;
        endcase
    end

    assign in_ready  = !full && !clear;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready && !clear;

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_addr    <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else if (clear) begin
            out_addr    <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (pop) out_addr <= out_addr + 32'd4;
            if (accept && !legal) begin
                illegal <= 1'b1;
                if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomised and directed bench for inst_encoder against an ISA-level
// encoder/decoder model and a queue-based FIFO model.
module tb_inst_encoder;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  t;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [19:0] imm;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  inst_type = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic [19:0] immediate = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic [2:0]  count;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int pass_cnt = 0;
    int total = 0;

    inst_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .inst_type(inst_type), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .func7(func7),
        .immediate(immediate), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .count(count),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Reference encoder: builds the ISA offset first, then scatters it.
    function automatic logic [31:0] enc(bundle_t b);
        logic [12:0] boff;
        logic [20:0] joff;
        boff = {b.imm[11:0], 1'b0};
        joff = {b.imm, 1'b0};
        case (b.t)
            4'd1: return {b.imm[11:0], b.rs1, b.f3, b.rd, 7'h03};
            4'd2: return {b.imm[11:5], b.rs2, b.rs1, b.f3, b.imm[4:0], 7'h23};
            4'd3: return {b.f7, b.rs2, b.rs1, b.f3, b.rd, 7'h33};
            4'd4: return {b.imm[11:0], b.rs1, b.f3, b.rd, 7'h13};
            4'd5: return {boff[12], boff[10:5], b.rs2, b.rs1, b.f3, boff[4:1], boff[11], 7'h63};
            4'd6: return {joff[20], joff[10:1], joff[11], joff[19:12], b.rd, 7'h6F};
            default: return 32'h0;
        endcase
    endfunction

    // Reference decoder: recovers the fields relevant to the bundle's type.
    function automatic bit decode_ok(logic [31:0] w, bundle_t b);
        logic [12:0] boff;
        logic [20:0] joff;
        boff = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        joff = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (b.t)
            4'd1: return w[6:0] == 7'h03 && w[11:7] == b.rd && w[14:12] == b.f3 &&
                         w[19:15] == b.rs1 && w[31:20] == b.imm[11:0];
            4'd2: return w[6:0] == 7'h23 && {w[31:25], w[11:7]} == b.imm[11:0] &&
                         w[14:12] == b.f3 && w[19:15] == b.rs1 && w[24:20] == b.rs2;
            4'd3: return w[6:0] == 7'h33 && w[11:7] == b.rd && w[14:12] == b.f3 &&
                         w[19:15] == b.rs1 && w[24:20] == b.rs2 && w[31:25] == b.f7;
            4'd4: return w[6:0] == 7'h13 && w[11:7] == b.rd && w[14:12] == b.f3 &&
                         w[19:15] == b.rs1 && w[31:20] == b.imm[11:0];
            4'd5: return w[6:0] == 7'h63 && boff[12:1] == b.imm[11:0] && w[14:12] == b.f3 &&
                         w[19:15] == b.rs1 && w[24:20] == b.rs2;
            4'd6: return w[6:0] == 7'h6F && joff[20:1] == b.imm && w[11:7] == b.rd;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bundle_t rand_bundle(logic [3:0] t);
        bundle_t b;
        b.t   = t;
        b.rd  = 5'($urandom);
        b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom);
        b.f3  = 3'($urandom);
        b.f7  = 7'($urandom);
        b.imm = 20'($urandom);
        return b;
    endfunction

    function automatic bundle_t mk(logic [3:0] t, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                   logic [2:0] f3, logic [6:0] f7, logic [19:0] imm);
        bundle_t b;
        b.t = t; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.f3 = f3; b.f7 = f7; b.imm = imm;
        return b;
    endfunction

    task automatic drive(bundle_t b, logic v);
        in_valid = v; inst_type = b.t; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
        func3 = b.f3; func7 = b.f7; immediate = b.imm;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic push_one(bundle_t b);
        drive(b, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [46:0] got, exp;
        got = {in_ready, out_valid, count, out_data, illegal, illegal_cnt};
        exp = {1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 8'h0};
        total++;
        if (got !== exp) $display("FAIL reset_state got=%h exp=%h", got, exp);
        else pass_cnt++;
        total++;
        if (out_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", out_addr);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        out_ready = 1'b0;
        do_clear();
        push_one(mk(4'd3, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0));
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h002081B3 || out_addr !== 32'h0)
            $display("FAIL r_type v=%b data=%h addr=%h exp 1/002081b3/0", out_valid, out_data, out_addr);
        else pass_cnt++;
        do_clear();
        push_one(mk(4'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'h7F, 20'h00FFF));
        push_one(mk(4'd2, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 20'h00008));
        total++;
        if (out_data !== 32'hFFF00293 || out_addr !== 32'h0 || count !== 3'd2)
            $display("FAIL i_alu data=%h addr=%h cnt=%0d exp fff00293/0/2", out_data, out_addr, count);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_data !== 32'h0020A423 || out_addr !== 32'h4)
            $display("FAIL store data=%h addr=%h exp 0020a423/4", out_data, out_addr);
        else pass_cnt++;
        do_clear();
        push_one(mk(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'h00004));
        total++;
        if (out_data !== 32'h008000EF) $display("FAIL jal data=%h exp 008000ef", out_data);
        else pass_cnt++;
        do_clear();
    endtask

    task automatic test_roundtrip();
        bundle_t b;
        out_ready = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            for (int k = 0; k < 3; k++) begin
                b = rand_bundle(4'(t));
                push_one(b);
                total++;
                if (out_data !== enc(b) || !decode_ok(out_data, b))
                    $display("FAIL roundtrip type=%0d data=%h exp %h", t, out_data, enc(b));
                else pass_cnt++;
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        end
        do_clear();
    endtask

    task automatic test_full();
        bundle_t b[5];
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) b[k] = rand_bundle(4'($urandom_range(1, 6)));
        for (int k = 0; k < 4; k++) begin
            drive(b[k], 1'b1);
            @(negedge clk);
        end
        drive(b[4], 1'b1);
        total++;
        if (in_ready !== 1'b0 || count !== 3'd4)
            $display("FAIL full_state in_ready=%b count=%0d exp 0/4", in_ready, count);
        else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL full_pop_ready in_ready=%b exp 0", in_ready);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (count !== 3'd3) $display("FAIL full_no_accept count=%0d exp 3", count);
        else pass_cnt++;
        for (int k = 1; k < 4; k++) begin
            total++;
            if (out_data !== enc(b[k]) || out_addr !== 32'(4 * k))
                $display("FAIL drain_%0d data=%h addr=%h exp %h/%h", k, out_data, out_addr, enc(b[k]), 4 * k);
            else pass_cnt++;
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_addr !== 32'd16)
            $display("FAIL drain_end v=%b cnt=%0d addr=%h exp 0/0/10", out_valid, count, out_addr);
        else pass_cnt++;
        // Popping an empty FIFO must not move the address.
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_addr !== 32'd16) $display("FAIL empty_pop addr=%h exp 10", out_addr);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        push_one(rand_bundle(4'd3));
        drive(rand_bundle(4'd4), 1'b1);
        clear = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL clear_ready in_ready=%b exp 0", in_ready);
        else pass_cnt++;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_addr !== 32'h0)
            $display("FAIL clear_flush cnt=%0d v=%b addr=%h exp 0/0/0", count, out_valid, out_addr);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        bundle_t b;
        b = rand_bundle(4'hF);
        push_one(b);
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || illegal !== 1'b1 || illegal_cnt !== 8'd1)
            $display("FAIL illegal_one cnt=%0d v=%b ill=%b icnt=%0d exp 0/0/1/1",
                     count, out_valid, illegal, illegal_cnt);
        else pass_cnt++;
        drive(rand_bundle(4'h0), 1'b1);
        for (int k = 0; k < 300; k++) @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (illegal_cnt !== 8'd255 || illegal !== 1'b1 || count !== 3'd0)
            $display("FAIL illegal_sat icnt=%0d ill=%b cnt=%0d exp 255/1/0", illegal_cnt, illegal, count);
        else pass_cnt++;
        do_clear();
        total++;
        if (illegal_cnt !== 8'd0 || illegal !== 1'b0)
            $display("FAIL illegal_clear icnt=%0d ill=%b exp 0/0", illegal_cnt, illegal);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bundle_t q[$];
        bundle_t b;
        logic [31:0] addr;
        logic [7:0]  icnt;
        logic        ill, v, r, c, lg;
        logic [44:0] got, exp;
        do_clear();
        addr = 0; icnt = 0; ill = 0;
        for (int i = 0; i < 400; i++) begin
            got = {out_valid, count, out_addr, ill_bit(), illegal_cnt};
            exp = {1'(q.size() > 0), 3'(q.size()), addr, ill, icnt};
            total++;
            if (got !== exp) $display("FAIL random_state cyc=%0d got=%h exp=%h", i, got, exp);
            else pass_cnt++;
            if (q.size() > 0) begin
                total++;
                if (out_data !== enc(q[0]) || !decode_ok(out_data, q[0]))
                    $display("FAIL random_data cyc=%0d data=%h exp %h", i, out_data, enc(q[0]));
                else pass_cnt++;
            end
            b = ($urandom_range(0, 4) == 0) ? rand_bundle(4'($urandom))
                                            : rand_bundle(4'($urandom_range(1, 6)));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 40) == 0);
            drive(b, v);
            out_ready = r;
            clear = c;
            #1;
            total++;
            if (in_ready !== (q.size() < DEPTH && !c))
                $display("FAIL random_ready cyc=%0d got=%b size=%0d clr=%b", i, in_ready, q.size(), c);
            else pass_cnt++;
            @(negedge clk);
            lg = (b.t >= 4'd1 && b.t <= 4'd6);
            if (c) begin
                q.delete(); addr = 0; ill = 0; icnt = 0;
            end else begin
                v = v && (q.size() < DEPTH);
                if (r && q.size() > 0) begin
                    void'(q.pop_front());
                    addr += 4;
                end
                if (v && lg) q.push_back(b);
                if (v && !lg) begin
                    ill = 1;
                    if (icnt != 8'hFF) icnt++;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        do_clear();
    endtask

    function automatic logic ill_bit();
        return illegal;
    endfunction

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_one(rand_bundle(4'($urandom_range(1, 6))));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (count !== 3'd3 || out_addr !== 32'h4)
            $display("FAIL pre_reset cnt=%0d addr=%h exp 3/4", count, out_addr);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_addr !== 32'h0 || out_data !== 32'h0)
            $display("FAIL async_reset cnt=%0d v=%b addr=%h data=%h exp all 0",
                     count, out_valid, out_addr, out_data);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        push_one(mk(4'd3, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0));
        total++;
        if (out_addr !== 32'h0 || out_data !== 32'h002081B3 || count !== 3'd1)
            $display("FAIL post_reset addr=%h data=%h cnt=%0d exp 0/002081b3/1", out_addr, out_data, count);
        else pass_cnt++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_roundtrip();
        test_full();
        test_clear();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
